alu_pipe: RTL and testbench

Parametrised, pipelined successor to the 16-bit combinational ALU. Operands and an opcode arrive over a valid/ready handshake and the result leaves through a registered output stage with backpressure. Shifts take a variable amount and run iteratively, one bit per cycle. The block sits between the operand-fetch stage and the writeback stage of the datapath, and reports carry, borrow, zero and negative flags alongside each result.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_core.sv | 56 +++++
 rtl/alu_pipe.sv | 137 +++++++++++++
 tb/tb_alu_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag types for the pipelined ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  typedef struct packed {
    logic carry;
    logic borrow;
    logic zero;
    logic neg;
  } flags_t;

  function automatic logic is_shift(input op_e op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath plus a one-bit shift step used by the iterative shifter.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  op_e              op,
  input  logic [WIDTH-1:0] sh_in,
  input  logic             sh_left,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             borrow,
  output logic [WIDTH-1:0] sh_res,
  output logic             sh_bit
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum    = {1'b0, x} + {1'b0, y};
    res    = x;
    carry  = 1'b0;
    borrow = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      OP_SUB: begin
        res    = x - y;
        borrow = (x < y);
      end
      OP_AND:  res = x & y;
      OP_OR:   res = x | y;
      OP_XOR:  res = x ^ y;
      OP_NOT:  res = ~x;
      // Shifts reaching here have amount zero: pass x through.
      default: res = x;
    endcase
  end

  always_comb begin
    sh_res = '0;
    sh_bit = 1'b0;
    if (sh_left) begin
      sh_res = {sh_in[WIDTH-2:0], 1'b0};
      sh_bit = sh_in[WIDTH-1];
    end else begin
      sh_res = {1'b0, sh_in[WIDTH-1:1]};
      sh_bit = sh_in[0];
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: valid/ready input, iterative one-bit-per-cycle shifter,
// registered result/flags stage with backpressure.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             zero_out,
  output logic             neg_out
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  flags_t           flags_q, flags_d;

  op_e              op;
  logic [SHW-1:0]   amt;
  logic             in_fire;
  logic             wr_result;
  logic [WIDTH-1:0] core_res;
  logic             core_carry;
  logic             core_borrow;
  logic [WIDTH-1:0] sh_res;
  logic             sh_bit;

  assign op       = op_e'(sel);
  assign amt      = y[SHW-1:0];
  assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .x       (x),
    .y       (y),
    .op      (op),
    .sh_in   (acc_q),
    .sh_left (left_q),
    .res     (core_res),
    .carry   (core_carry),
    .borrow  (core_borrow),
    .sh_res  (sh_res),
    .sh_bit  (sh_bit)
  );

  // Next-state, shifter and output-stage update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    alu_out_d   = alu_out_q;
    flags_d     = flags_q;
    wr_result   = 1'b0;
    out_valid_d = out_valid_q && !out_ready;

    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          if (is_shift(op) && (amt != '0)) begin
            state_d = ST_SHIFT;
            acc_d   = x;
            cnt_d   = amt;
            left_d  = (op == OP_SHL);
          end else begin
            wr_result      = 1'b1;
            alu_out_d      = core_res;
            flags_d.carry  = core_carry;
            flags_d.borrow = core_borrow;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = sh_res;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d        = ST_IDLE;
          wr_result      = 1'b1;
          alu_out_d      = sh_res;
          flags_d.carry  = sh_bit;
          flags_d.borrow = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_result) begin
      out_valid_d = 1'b1;
    end
    flags_d.zero = (alu_out_d == '0);
    flags_d.neg  = alu_out_d[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_out    = alu_out_q;
  assign carry_out  = flags_q.carry;
  assign borrow_out = flags_q.borrow;
  assign zero_out   = flags_q.zero;
  assign neg_out    = flags_q.neg;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=16 and WIDTH=8.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] x, y, alu_out;
  logic [2:0]  sel;
  logic        carry_out, borrow_out, zero_out, neg_out;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  x8, y8, alu_out8;
  logic [2:0]  sel8;
  logic        carry8, borrow8, zero8, neg8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .carry_out(carry_out), .borrow_out(borrow_out),
    .zero_out(zero_out), .neg_out(neg_out)
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .y(y8), .sel(sel8), .out_valid(out_valid8), .out_ready(out_ready8),
    .alu_out(alu_out8), .carry_out(carry8), .borrow_out(borrow8),
    .zero_out(zero8), .neg_out(neg8)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  s;
    logic [15:0] r;
    bit          c;
    bit          bo;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic on wide integers; lat = edges from accept to visible result.
  task automatic ref_model(input int w, input longint unsigned a_in, input longint unsigned b_in,
                           input int s, output longint unsigned r, output bit c,
                           output bit bo, output int lat);
    longint unsigned m, a, b;
    int k;
    m   = (64'd1 << w) - 64'd1;
    a   = a_in & m;
    b   = b_in & m;
    k   = int'(b % 64'(w));
    r   = 0;
    c   = 1'b0;
    bo  = 1'b0;
    lat = 0;
    case (s)
      0: begin r = (a + b) & m; c = 1'(((a + b) >> w) & 64'd1); end
      1: begin r = (a - b) & m; bo = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a & m;
      6: begin
        r = (a << k) & m;
        if (k != 0) c = 1'((a >> (w - k)) & 64'd1);
        lat = k;
      end
      default: begin
        r = a >> k;
        if (k != 0) c = 1'((a >> (k - 1)) & 64'd1);
        lat = k;
      end
    endcase
  endtask

  // Issue one op on the 16-bit DUT with out_ready=1 and check timing, result and flags.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s,
                       input logic [15:0] er, input bit ec, input bit eb, input int elat,
                       input string nm);
    int  g;
    int  lat;
    bit  rdy_seen;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check({nm, " accept_timeout"}, 32'(g >= 50), 32'd0);
    x = a; y = b; sel = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1 lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(elat));
    check({nm, " alu_out"}, 32'(alu_out), 32'(er));
    check({nm, " carry"}, 32'(carry_out), 32'(ec));
    check({nm, " borrow"}, 32'(borrow_out), 32'(eb));
    check({nm, " zero"}, 32'(zero_out), 32'(er == 16'h0));
    check({nm, " neg"}, 32'(neg_out), 32'(er[15]));
    check({nm, " in_ready_during_shift"}, 32'(rdy_seen), 32'd0);
  endtask

  initial begin
    longint unsigned rr;
    bit rc, rb, ov_seen;
    int rl;
    logic [15:0] ra, rbv;
    logic [2:0]  rs;
    logic [7:0]  ea8;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; sel = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; x8 = '0; y8 = '0; sel8 = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst alu_out", 32'(alu_out), 32'd0);
    check("rst flags", 32'({carry_out, borrow_out, zero_out, neg_out}), 32'd0);
    rst_n = 1'b1;
    #1 check("post-rst in_ready", 32'(in_ready), 32'd1);

    // Directed vector table.
    tbl.push_back('{16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1'b1, 1'b0, 0});
    tbl.push_back('{16'h0001, 16'h0002, 3'b001, 16'hFFFF, 1'b0, 1'b1, 0});
    tbl.push_back('{16'h0005, 16'h0002, 3'b001, 16'h0003, 1'b0, 1'b0, 0});
    tbl.push_back('{16'h8001, 16'h0004, 3'b110, 16'h0010, 1'b0, 1'b0, 4});
    tbl.push_back('{16'h8000, 16'h000F, 3'b111, 16'h0001, 1'b0, 1'b0, 15});
    tbl.push_back('{16'h1234, 16'h0010, 3'b110, 16'h1234, 1'b0, 1'b0, 0});
    tbl.push_back('{16'h0003, 16'h0001, 3'b111, 16'h0001, 1'b1, 1'b0, 1});
    tbl.push_back('{16'hC000, 16'h0001, 3'b110, 16'h8000, 1'b1, 1'b0, 1});
    tbl.push_back('{16'hF0F0, 16'h3C3C, 3'b010, 16'h3030, 1'b0, 1'b0, 0});
    tbl.push_back('{16'h00FF, 16'h1234, 3'b101, 16'hFF00, 1'b0, 1'b0, 0});
    tbl.push_back('{16'h7FFF, 16'h0001, 3'b000, 16'h8000, 1'b0, 1'b0, 0});
    tbl.push_back('{16'h0003, 16'h0003, 3'b001, 16'h0000, 1'b0, 1'b0, 0});
    tbl.push_back('{16'h0F0F, 16'hF0F0, 3'b100, 16'hFFFF, 1'b0, 1'b0, 0});
    for (int i = 0; i < tbl.size(); i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].r, tbl[i].c, tbl[i].bo, tbl[i].lat,
            $sformatf("vec%0d", i));

    // Backpressure: OR result held while out_ready=0; a pending op waits.
    @(negedge clk);
    out_ready = 1'b0;
    #1 check("bp in_ready_before", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 check("bp drain_blocked", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp idle in_ready", 32'(in_ready), 32'(!out_valid));
    x = 16'h0F0F; y = 16'hF0F0; sel = 3'b011; in_valid = 1'b1;
    @(posedge clk);
    #1;
    x = 16'h0001; y = 16'h0001; sel = 3'b000;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp hold alu_out c%0d", i), 32'(alu_out), 32'h0000FFFF);
      check($sformatf("bp hold valid c%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp hold in_ready c%0d", i), 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("bp in_ready_rise", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp second_op", 32'(alu_out), 32'h00000002);
    check("bp second_valid", 32'(out_valid), 32'd1);

    // Reset in the middle of an 8-step shift.
    @(negedge clk);
    check("mid-rst accept_ready", 32'(in_ready), 32'd1);
    x = 16'h0001; y = 16'h0008; sel = 3'b110; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    ov_seen = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1 if (out_valid) ov_seen = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("mid-rst in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("mid-rst out_valid", 32'(out_valid), 32'd0);
    check("mid-rst alu_out", 32'(alu_out), 32'd0);
    check("mid-rst flags", 32'({carry_out, borrow_out, zero_out, neg_out}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid-rst in_ready_after", 32'(in_ready), 32'd1);
    repeat (12) begin
      @(posedge clk);
      #1 if (out_valid) ov_seen = 1'b1;
    end
    check("mid-rst no_out_valid", 32'(ov_seen), 32'd0);

    // Randomised ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      ra  = 16'($urandom);
      rbv = 16'($urandom);
      rs  = 3'($urandom_range(0, 7));
      ref_model(16, 64'(ra), 64'(rbv), int'(rs), rr, rc, rb, rl);
      do_op(ra, rbv, rs, 16'(rr), rc, rb, rl, $sformatf("rnd%0d", i));
    end

    // WIDTH=8 instance: directed XOR/NOT, then back-to-back random non-shift ops.
    @(negedge clk);
    x8 = 8'hAA; y8 = 8'h55; sel8 = 3'b100; in_valid8 = 1'b1;
    @(posedge clk);
    #1 check("w8 xor", 32'(alu_out8), 32'h000000FF);
    check("w8 xor neg", 32'(neg8), 32'd1);
    @(negedge clk);
    x8 = 8'h34; sel8 = 3'b101;
    @(posedge clk);
    #1 check("w8 not", 32'(alu_out8), 32'h000000CB);
    check("w8 not valid", 32'(out_valid8), 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check($sformatf("w8 rnd%0d ready", i), 32'(in_ready8), 32'd1);
      x8   = 8'($urandom);
      y8   = (i % 5 == 0) ? 8'(8 * $urandom_range(0, 31)) : 8'($urandom);
      sel8 = (i % 5 == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      ref_model(8, 64'(x8), 64'(y8), int'(sel8), rr, rc, rb, rl);
      ea8 = 8'(rr);
      @(posedge clk);
      #1;
      check($sformatf("w8 rnd%0d alu_out", i), 32'(alu_out8), 32'(ea8));
      check($sformatf("w8 rnd%0d flags", i), 32'({carry8, borrow8, zero8, neg8}),
            32'({rc, rb, ea8 == 8'h0, ea8[7]}));
    end
    in_valid8 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
